// File: rtl/fork_pkg.sv
// fork_pkg: shared definitions for the fork_fsplit byte splitter.
//   DefaultSize  - default width of each output branch
//   split_word_t - one input word viewed as its {hi, lo} halves
package fork_pkg;

  localparam int DefaultSize = 8;

  typedef struct packed {
    logic [DefaultSize-1:0] hi;
    logic [DefaultSize-1:0] lo;
  } split_word_t;

endpackage

// File: rtl/fflop.sv
// fflop: two-entry elastic valid/retry stage (fluid flop).
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   din/dinValid         - upstream data and valid
//   dinRetry             - upstream stall, high only when both entries are full
//   q/qValid             - downstream data (oldest entry) and valid
//   qRetry               - downstream stall
// dinRetry comes straight from the occupancy register, so it never depends
// combinationally on qRetry and stages can be chained without loops.
module fflop #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] din,
  input  logic             dinValid,
  output logic             dinRetry,
  output logic [Width-1:0] q,
  output logic             qValid,
  input  logic             qRetry
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  // Head always holds the oldest word; tail is only used when two are held.
  always_comb begin
    push    = dinValid && (count_q != 2'd2);
    pop     = (count_q != 2'd0) && !qRetry;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = din;
        else                 tail_d = din;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Simultaneous push and pop only happens with exactly one entry held.
      2'b11: head_d = din;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign q        = head_q;
  assign qValid   = (count_q != 2'd0);
  assign dinRetry = (count_q == 2'd2);

endmodule

// File: rtl/fork_fsplit.sv
// fork_fsplit: forks one valid/retry stream of 2*Size-bit words into two
// Size-bit streams; branch A carries the low half, branch B the high half.
// Every accepted word reaches each branch exactly once, in input order.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   inp/inpValid/inpRetry          - input word stream
//   out_a/out_aValid/out_aRetry    - branch A (inp[Size-1:0])
//   out_b/out_bValid/out_bRetry    - branch B (inp[2*Size-1:Size])
// Configuration macro:
//   FORK_EAGER_EN - defined: eager fork, branches drain independently and a
//                   done bit per branch remembers which half already left.
//                   undefined: lockstep fork, both halves leave together.
module fork_fsplit
  import fork_pkg::*;
#(
  parameter int Size = DefaultSize
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2*Size-1:0] inp,
  input  logic              inpValid,
  output logic              inpRetry,
  output logic [Size-1:0]   out_a,
  output logic              out_aValid,
  input  logic              out_aRetry,
  output logic [Size-1:0]   out_b,
  output logic              out_bValid,
  input  logic              out_bRetry
);

  logic [2*Size-1:0] w;
  logic              wValid, wRetry;
  logic              aValid, aRetry;
  logic              bValid, bRetry;

  fflop #(.Width(2*Size)) f_in (
    .clk      (clk),
    .reset    (reset),
    .din      (inp),
    .dinValid (inpValid),
    .dinRetry (inpRetry),
    .q        (w),
    .qValid   (wValid),
    .qRetry   (wRetry)
  );

`ifdef FORK_EAGER_EN
  logic doneA_q, doneA_d;
  logic doneB_q, doneB_d;
  logic fireA, fireB, wordRelease;

  // A branch keeps requesting until its half has been taken; the word is
  // released once both halves are out, which clears the done bits so that a
  // simultaneous double fire never sets them at all.
  always_comb begin
    aValid      = wValid && !doneA_q;
    bValid      = wValid && !doneB_q;
    fireA       = aValid && !aRetry;
    fireB       = bValid && !bRetry;
    wordRelease = wValid && (fireA || doneA_q) && (fireB || doneB_q);
    wRetry      = !wordRelease;
    if (wordRelease) begin
      doneA_d = 1'b0;
      doneB_d = 1'b0;
    end else begin
      doneA_d = doneA_q || fireA;
      doneB_d = doneB_q || fireB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      doneA_q <= 1'b0;
      doneB_q <= 1'b0;
    end else begin
      doneA_q <= doneA_d;
      doneB_q <= doneB_d;
    end
  end
`else
  logic fireBoth;

  // Both halves move only together; a stall on either side holds the word.
  // The output stages' dinRetry is registered, so this forms no loop.
  always_comb begin
    fireBoth = wValid && !aRetry && !bRetry;
    aValid   = fireBoth;
    bValid   = fireBoth;
    wRetry   = !fireBoth;
  end
`endif

  fflop #(.Width(Size)) f_a (
    .clk      (clk),
    .reset    (reset),
    .din      (w[Size-1:0]),
    .dinValid (aValid),
    .dinRetry (aRetry),
    .q        (out_a),
    .qValid   (out_aValid),
    .qRetry   (out_aRetry)
  );

  fflop #(.Width(Size)) f_b (
    .clk      (clk),
    .reset    (reset),
    .din      (w[2*Size-1:Size]),
    .dinValid (bValid),
    .dinRetry (bRetry),
    .q        (out_b),
    .qValid   (out_bValid),
    .qRetry   (out_bRetry)
  );

endmodule

// File: tb/tb_fork_fsplit.sv
// tb_fork_fsplit: self-checking bench for fork_fsplit. A per-branch queue of
// expected bytes is filled whenever a word is accepted and drained whenever a
// branch delivers; directed phases cover latency, streaming, backpressure,
// alternating stalls and reset mid-word, followed by a long random phase.
module tb_fork_fsplit;
  import fork_pkg::*;

  localparam int Size = DefaultSize;
`ifdef FORK_EAGER_EN
  localparam int MaxLead = 3;
`else
  localparam int MaxLead = 2;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2*Size-1:0] inp = '0;
  logic              inpValid = 1'b0;
  logic              inpRetry;
  logic [Size-1:0]   out_a, out_b;
  logic              out_aValid, out_bValid;
  logic              out_aRetry = 1'b0;
  logic              out_bRetry = 1'b0;

  always #5 clk = ~clk;

  fork_fsplit #(.Size(Size)) dut (
    .clk        (clk),
    .reset      (reset),
    .inp        (inp),
    .inpValid   (inpValid),
    .inpRetry   (inpRetry),
    .out_a      (out_a),
    .out_aValid (out_aValid),
    .out_aRetry (out_aRetry),
    .out_b      (out_b),
    .out_bValid (out_bValid),
    .out_bRetry (out_bRetry)
  );

  int errors = 0;
  int checks = 0;

  logic [Size-1:0]   expA[$];
  logic [Size-1:0]   expB[$];
  int                deliveredA = 0, deliveredB = 0, accepted = 0;
  int                wordsLeft = 0, cycleNo = 0, maxLead = 0;
  logic [2*Size-1:0] nextWord = '0;
  bit                seqWords = 0, holdIn = 0, sawInpRetry = 0;
  bit                prevAStall = 0, prevBStall = 0;
  logic [Size-1:0]   prevA = '0, prevB = '0;

  // One comparison: counts it, and counts and reports it when it misses.
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Reference model and protocol monitor, evaluated mid-cycle while all
  // inputs and outputs are stable: whatever is valid and not retried now
  // transfers at the coming edge.
  task automatic checkOutput();
    split_word_t sw;
    int lead;
    cycleNo++;
    if (reset) begin
      expA.delete();
      expB.delete();
      holdIn     = 0;
      prevAStall = 0;
      prevBStall = 0;
      return;
    end
    if (prevAStall) begin
      check("aHoldValid", out_aValid, 1);
      check("aHoldData", out_a, prevA);
    end
    if (prevBStall) begin
      check("bHoldValid", out_bValid, 1);
      check("bHoldData", out_b, prevB);
    end
    if (out_aValid && !out_aRetry) begin
      if (expA.size() == 0) check("aSpurious", out_aValid, 0);
      else begin
        check("aData", out_a, expA.pop_front());
        deliveredA++;
      end
    end
    if (out_bValid && !out_bRetry) begin
      if (expB.size() == 0) check("bSpurious", out_bValid, 0);
      else begin
        check("bData", out_b, expB.pop_front());
        deliveredB++;
      end
    end
    prevAStall = out_aValid && out_aRetry;
    prevBStall = out_bValid && out_bRetry;
    prevA      = out_a;
    prevB      = out_b;
    if (inpRetry) sawInpRetry = 1;
    if (inpValid && !inpRetry) begin
      sw = inp;
      expA.push_back(sw.lo);
      expB.push_back(sw.hi);
      accepted++;
      if (wordsLeft > 0) wordsLeft--;
      nextWord = seqWords ? nextWord + 1'b1 : (2*Size)'($urandom);
      holdIn   = 0;
    end else begin
      holdIn = inpValid;
    end
    lead = deliveredB - deliveredA;
    if (lead < 0) lead = -lead;
    if (lead > maxLead) maxLead = lead;
  endtask

  // One clock cycle of stimulus. Probabilities are percentages; a negative
  // retry probability selects the alternating pattern (A on odd, B on even).
  task automatic applyStimulus(input int pValid, input int pRa, input int pRb);
    @(posedge clk);
    #1;
    if (!holdIn) begin
      if (wordsLeft > 0 && int'($urandom_range(99)) < pValid) begin
        inpValid = 1'b1;
        inp      = nextWord;
      end else begin
        inpValid = 1'b0;
        inp      = (2*Size)'($urandom);
      end
    end
    out_aRetry = (pRa < 0) ? cycleNo[0]  : (int'($urandom_range(99)) < pRa);
    out_bRetry = (pRb < 0) ? !cycleNo[0] : (int'($urandom_range(99)) < pRb);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runUntilDrained(input string tag, input int budget,
                                 input int pRa, input int pRb);
    int n = 0;
    while ((wordsLeft > 0 || holdIn || expA.size() != 0 || expB.size() != 0)
           && n < budget) begin
      applyStimulus(100, pRa, pRb);
      n++;
    end
    check({tag, "Pending"}, wordsLeft + int'(holdIn) + expA.size() + expB.size(), 0);
  endtask

  task automatic clearCounts();
    deliveredA  = 0;
    deliveredB  = 0;
    accepted    = 0;
    maxLead     = 0;
    sawInpRetry = 0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset      = 1'b1;
    inpValid   = 1'b0;
    out_aRetry = 1'b0;
    out_bRetry = 1'b0;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstAValid", out_aValid, 0);
    check("rstBValid", out_bValid, 0);
    check("rstInpRetry", inpRetry, 0);
    check("rstAData", out_a, 0);
    check("rstBData", out_b, 0);
    checkOutput();
    clearCounts();
  endtask

  initial begin
    doReset();

    // Single word, latency and one-cycle valid pulse.
    seqWords  = 0;
    nextWord  = 16'hBEEF;
    wordsLeft = 1;
    applyStimulus(100, 0, 0);
    check("beefAccepted", accepted, 1);
    applyStimulus(100, 0, 0);
    check("beefEarlyA", out_aValid, 0);
    check("beefEarlyB", out_bValid, 0);
    applyStimulus(100, 0, 0);
    check("beefValidA", out_aValid, 1);
    check("beefValidB", out_bValid, 1);
    check("beefDataA", out_a, 8'hEF);
    check("beefDataB", out_b, 8'hBE);
    applyStimulus(100, 0, 0);
    check("beefPulseA", out_aValid, 0);
    check("beefPulseB", out_bValid, 0);

    // Back-to-back stream with free consumers: never backpressured.
    clearCounts();
    seqWords  = 1;
    nextWord  = 16'h0001;
    wordsLeft = 16;
    repeat (16) applyStimulus(100, 0, 0);
    check("streamNoRetry", sawInpRetry, 0);
    check("streamAccepted", accepted, 16);
    runUntilDrained("stream", 20, 0, 0);
    check("streamCountA", deliveredA, 16);
    check("streamCountB", deliveredB, 16);

    // Branch A stalled while streaming: B runs ahead only as far as buffering.
    clearCounts();
    nextWord  = 16'h0100;
    wordsLeft = 12;
    repeat (10) applyStimulus(100, 100, 0);
    check("stallLead", maxLead, MaxLead);
    check("stallBackpressure", sawInpRetry, 1);
    check("stallANone", deliveredA, 0);
    runUntilDrained("stallDrain", 60, 0, 0);
    check("stallCountA", deliveredA, 12);
    check("stallCountB", deliveredB, 12);

    // Alternating single-branch stalls over 32 words.
    clearCounts();
    nextWord  = 16'h2000;
    wordsLeft = 32;
    runUntilDrained("alt", 300, -1, -1);
    check("altCountA", deliveredA, 32);
    check("altCountB", deliveredB, 32);

    // Reset while 16'h1234 is only partly delivered (A stalled).
    clearCounts();
    nextWord  = 16'h1232;
    wordsLeft = 3;
    repeat (8) applyStimulus(100, 100, 0);
    check("halfLeadB", deliveredB, MaxLead);
    check("halfNoneA", deliveredA, 0);
    doReset();
    seqWords  = 0;
    nextWord  = 16'h5678;
    wordsLeft = 1;
    applyStimulus(100, 0, 0);
    applyStimulus(100, 0, 0);
    check("postRstEarlyA", out_aValid, 0);
    applyStimulus(100, 0, 0);
    check("postRstValidA", out_aValid, 1);
    check("postRstValidB", out_bValid, 1);
    check("postRstDataA", out_a, 8'h78);
    check("postRstDataB", out_b, 8'h56);
    repeat (6) applyStimulus(0, 0, 0);
    check("postRstCountA", deliveredA, 1);
    check("postRstCountB", deliveredB, 1);

    // Long random run against the scoreboard.
    clearCounts();
    nextWord  = (2*Size)'($urandom);
    wordsLeft = 1000000;
    for (int i = 0; i < 10000; i++) begin
      if (i < 3000) applyStimulus(70, 30, 30);
      else if (i < 6000) applyStimulus(90, 80, 10);
      else applyStimulus(50, 20, 60);
    end
    wordsLeft = 0;
    runUntilDrained("random", 200, 0, 0);
    check("randomLeadBound", maxLead <= MaxLead, 1);
    check("randomCountA", deliveredA, accepted);
    check("randomCountB", deliveredB, accepted);
    check("randomProgress", accepted > 1000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
